// File: rtl/sram_responder.sv
// sram_responder: clocked device-side model of the board's asynchronous
// 16-bit SRAM. It samples the controller's address and strobes, stores write
// data in an internal array and drives the shared data bus on reads.
//
// Optional build macro: SRAM_RESPONDER_PROTO_CHECK_EN
//   defined     -> protoError is a sticky protocol-violation flag
//   not defined -> protoError is tied to 0 and no check logic exists
//
// Pin protocol: every pin is sampled at the rising clock edge. The strobes are
// active-low. A write request is chip-select plus write-enable. A read request
// is chip-select plus output-enable with write-enable high. A write is
// committed at the first edge where the write request is gone, using the
// address and data from the last edge that still saw it. A read drives the
// bus READ_LAT edges after it is sampled. The bus is released one edge after
// the read request is gone or the address moves.
module sram_responder #(
  parameter int ADDR_W     = 18,
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 12,
  parameter int READ_LAT   = 1
) (
  input  logic              clk,
  input  logic              rst,
  inout  wire  [DATA_W-1:0] memDataBus,
  input  logic [ADDR_W-1:0] memAddrBus,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic              memEnable,
  output logic [15:0]       readCount,
  output logic [15:0]       writeCount,
  output logic              protoError,
  output logic [1:0]        stateDbg
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITE     = 2'd1,
    READ_WAIT = 2'd2,
    DRIVE     = 2'd3
  } stateT;

  // Latency counter reload value; READ_LAT=1 goes straight to DRIVE.
  localparam logic [3:0] LOAD_VAL = 4'(READ_LAT - 1);

  stateT             state;
  stateT             stateNext;
  logic [ADDR_W-1:0] addrLatch;
  logic [ADDR_W-1:0] addrNext;
  logic [DATA_W-1:0] dataLatch;
  logic [DATA_W-1:0] dataNext;
  logic [3:0]        latCnt;
  logic [3:0]        cntNext;
  logic              driveEn;
  logic              driveNext;
  logic              commitEn;
  logic              readInc;
  logic              restart;

  logic              chipSel;
  logic              wrReq;
  logic              rdReq;
  logic              addrMoved;

  logic [DATA_W-1:0] memArr [2**DEPTH_LOG2];

  assign chipSel   = !memEnable;
  assign wrReq     = chipSel && !memWrite;
  assign rdReq     = chipSel && !memRead && memWrite;
  assign addrMoved = (memAddrBus != addrLatch);
  assign stateDbg  = state;

  // Bus carries the addressed word only while the read is being served.
  assign memDataBus = driveEn ? memArr[addrLatch[DEPTH_LOG2-1:0]] : {DATA_W{1'bz}};

  // Next-state and datapath decisions; "restart" applies the idle-state rules.
  always_comb begin
    stateNext = state;
    addrNext  = addrLatch;
    dataNext  = dataLatch;
    cntNext   = latCnt;
    driveNext = 1'b0;
    commitEn  = 1'b0;
    readInc   = 1'b0;
    restart   = 1'b0;
    case (state)
      IDLE: restart = 1'b1;
      WRITE: begin
        if (wrReq) begin
          addrNext = memAddrBus;
          dataNext = memDataBus;
        end else begin
          commitEn = 1'b1;
          restart  = 1'b1;
        end
      end
      READ_WAIT: begin
        if (rdReq && !addrMoved) begin
          cntNext = latCnt - 4'd1;
          if (latCnt == 4'd1) stateNext = DRIVE;
        end else begin
          restart = 1'b1;
        end
      end
      DRIVE: begin
        if (rdReq && !addrMoved) begin
          driveNext = 1'b1;
          readInc   = !driveEn;
        end else begin
          restart = 1'b1;
        end
      end
      default: restart = 1'b1;
    endcase
    if (restart) begin
      stateNext = IDLE;
      if (wrReq) begin
        stateNext = WRITE;
        addrNext  = memAddrBus;
        dataNext  = memDataBus;
      end else if (rdReq) begin
        addrNext  = memAddrBus;
        cntNext   = LOAD_VAL;
        stateNext = (LOAD_VAL != 4'd0) ? READ_WAIT : DRIVE;
      end
    end
  end

  // State, latches, bus enable and access counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      addrLatch  <= '0;
      dataLatch  <= '0;
      latCnt     <= '0;
      driveEn    <= 1'b0;
      readCount  <= '0;
      writeCount <= '0;
    end else begin
      state     <= stateNext;
      addrLatch <= addrNext;
      dataLatch <= dataNext;
      latCnt    <= cntNext;
      driveEn   <= driveNext;
      if (commitEn) writeCount <= writeCount + 16'd1;
      if (readInc)  readCount  <= readCount + 16'd1;
    end
  end

  // Array commit; contents survive reset, and reset forces IDLE so a pending
  // write is simply dropped.
  always_ff @(posedge clk) begin
    if (commitEn) memArr[addrLatch[DEPTH_LOG2-1:0]] <= dataLatch;
  end

`ifdef SRAM_RESPONDER_PROTO_CHECK_EN
  logic violation;
  assign violation = (chipSel && !memRead && !memWrite)
                  || (!memWrite && driveEn)
                  || ((state == WRITE) && wrReq && addrMoved);

  // Sticky violation flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) protoError <= 1'b0;
    else if (violation) protoError <= 1'b1;
  end
`else
  assign protoError = 1'b0;
`endif

endmodule

// File: doc/sram_responder.md
# sram_responder

Clocked, synthesizable model of the board's asynchronous 16-bit SRAM as seen from the memory controller's pins. It is the device end of the memory controller's external protocol: it samples the address bus and control strobes, stores write data in an internal array, and drives the shared tri-state data bus on reads. It replaces the physical SRAM in simulation and in FPGA loopback builds, and provides access counters and a protocol-violation flag for the verification bench.

## Interface

Parameters:
- ADDR_W, 18, width of the address bus.
- DATA_W, 16, width of the data bus.
- DEPTH_LOG2, 12, number of implemented address bits; the array holds 2^DEPTH_LOG2 words.
- READ_LAT, 1, cycles from the sampled read request until the bus is driven; legal range is 1 to 15.

Ports:
- clk  in  1  the single clock; every state element uses its rising edge.
- rst  in  1  asynchronous, active-high reset.
- memDataBus  inout  DATA_W  shared data bus; high-Z unless this block is driving it.
- memAddrBus  in  ADDR_W  word address.
- memRead  in  1  output enable, active-low.
- memWrite  in  1  write enable, active-low.
- memEnable  in  1  chip enable, active-low.
- readCount  out  16  number of completed reads.
- writeCount  out  16  number of committed writes.
- protoError  out  1  sticky protocol-violation flag.

## Operation

- All pins are sampled at the rising edge of clk.
- Requests:
  - Chip selected when memEnable=0.
  - Write request (WR): selected and memWrite=0.
  - Read request (RD): selected, memRead=0 and memWrite=1.
  - WR takes priority when both strobes are low.
- Array index is memAddrBus[DEPTH_LOG2-1:0]. Upper address bits alias.
- States are IDLE, WRITE, READ_WAIT and DRIVE.
  - IDLE
    - WR: latch addr and data, go to WRITE.
    - RD: latch addr, load latency counter with READ_LAT-1, go to READ_WAIT if the loaded value is nonzero, otherwise go to DRIVE.
  - WRITE
    - While WR holds, re-latch addr and data on every edge.
    - When WR is gone: commit the latched data to mem[latched addr] and increment writeCount. Then go to DRIVE or READ_WAIT if RD is present (same rules as IDLE), otherwise go to IDLE.
  - READ_WAIT
    - Counter decrements each edge. Go to DRIVE when it reaches 0.
    - If the address changes or RD drops, restart from IDLE rules.
  - DRIVE
    - driveEn=1 and the bus carries mem[latched addr]. readCount increments once on entry.
    - If the address changes while RD holds, clear driveEn and restart the latency count (new read).
    - If RD drops, clear driveEn and follow IDLE rules.
- The bus is tri-stated whenever driveEn=0.
- readCount and writeCount wrap from 0xFFFF to 0.
- Reset values: state=IDLE, driveEn=0 (bus high-Z), readCount=0, writeCount=0, protoError=0. Array contents are not reset.
- Reset mid-write discards the uncommitted write. Reset mid-read releases the bus immediately, because the reset is asynchronous.

## Timing

- Read: the request is sampled at edge E0. The bus is driven from edge E0+READ_LAT until the edge after RD is sampled deasserted, so release takes at most one clk.
- Write commit happens at the first edge where WR is sampled absent (WE rising). Data and address are taken from the last edge at which WR was sampled.
- Read-after-write to the same address: the new data is returned, because the commit precedes the DRIVE entry.
- Back-to-back reads at different addresses with RD held: each address costs READ_LAT cycles.

## Configuration

- SRAM_RESPONDER_PROTO_CHECK_EN
  - Defined: protoError is set and held until rst when any of these is sampled:
    - memRead=0 and memWrite=0 with the chip selected.
    - memWrite=0 while driveEn=1 (bus contention).
    - The address changes while WR is held.
  - Not defined: protoError is tied to 0 and no check logic is built.

## Test plan

- Reset, then write 0xBEEF to 0x00010 with a single-cycle WR, then read 0x00010 with READ_LAT=1. Required: the bus shows 0xBEEF one cycle after the request, writeCount=1, readCount=1.
- With READ_LAT=3, read 0x00020 holding RD. Required: the bus stays high-Z for 3 edges, then is driven. Changing the address to 0x00021 while RD is held releases the bus and drives again 3 cycles later. readCount=2.
- Write 0x1234 to 0x01005 with DEPTH_LOG2=12, then read 0x00005. Required: 0x1234 (aliasing).
- Assert rst in the middle of a 3-cycle WR of 0xAAAA to 0x00030, which previously held 0x5555. Required: the bus is high-Z at once, the counters read 0, and a later read returns 0x5555.
- With the macro defined, drive memRead=0 and memWrite=0 together on a selected chip. Required: the write commits, protoError=1 and stays 1 until rst. With the macro undefined: protoError=0.
- Perform 65536 writes. Required: writeCount wraps to 0.
